fifo_burst_reader: RTL

Read-side controller for the team's synchronous FIFO. It drains the FIFO with `fifo_rd_en`, absorbs the FIFO's one-cycle registered read latency, and presents the words as a valid/ready stream framed into bursts with `m_last`. A burst starts when the FIFO holds a full burst, when a partial-fill timeout expires, or on an explicit flush. It sits between the FIFO's read port and any downstream packet consumer, such as a DMA or serializer.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/stream_skid_buf.sv | 78 +++++++
 rtl/fifo_burst_reader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side controllers.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // Occupancy counter width for a FIFO holding up to depth words.
  function automatic int unsigned usedw_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry {data, last} stream buffer with an empty-buffer bypass, so a word
// arriving into an empty buffer is presented in the same cycle.
module stream_skid_buf #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready_c,
  output logic                  out_valid_c,
  output logic [DATA_WIDTH-1:0] out_data_c,
  output logic                  out_last_c,
  input  logic                  out_ready,
  output logic [1:0]            held
);

  localparam int unsigned EW = DATA_WIDTH + 1;

  logic [EW-1:0] ent0_q, ent0_d;
  logic [EW-1:0] ent1_q, ent1_d;
  logic [1:0]    held_q, held_d;
  logic [EW-1:0] in_ent;
  logic          bypass;
  logic          push;
  logic          pop;

  assign in_ent      = {in_last, in_data};
  assign bypass      = (held_q == 2'd0) && in_valid;
  assign out_valid_c = !sclr && ((held_q != 2'd0) || in_valid);
  assign out_data_c  = bypass ? in_data : ent0_q[DATA_WIDTH-1:0];
  assign out_last_c  = bypass ? in_last : ent0_q[DATA_WIDTH];
  assign in_ready_c  = (held_q != 2'd2) || out_ready;
  assign push        = in_valid && in_ready_c;
  assign pop         = out_valid_c && out_ready;
  assign held        = held_q;

  // Entry 0 is always the oldest word; a pop shifts entry 1 down.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    held_d = held_q;
    unique case ({push, pop})
      2'b10: begin
        if (held_q == 2'd0) ent0_d = in_ent;
        else                ent1_d = in_ent;
        held_d = held_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        held_d = held_q - 2'd1;
      end
      2'b11: begin
        if (held_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = in_ent;
        end else if (held_q == 2'd1) begin
          ent0_d = in_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      ent0_q <= '0;
      ent1_q <= '0;
      held_q <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      held_q <= held_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the synchronous FIFO in bursts and presents the words as a
// valid/ready stream framed with m_last.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic                          enable,
  input  logic                          flush,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  input  logic                          fifo_empty,
  input  logic [usedw_width(DEPTH)-1:0] fifo_usedw,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          busy
);

  localparam int unsigned UW = usedw_width(DEPTH);
  localparam int unsigned CW = $clog2(BURST_LEN + 1);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [UW-1:0] BL_U = UW'(BURST_LEN);
  localparam logic [TW-1:0] TO_T = TW'(TIMEOUT);

  burst_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;

  logic          rd_go;
  logic          pop_c;
  logic          skid_in_ready_c;
  logic [1:0]    held;
  logic [2:0]    occ_next_c;
  logic          partial_c;
  logic          trigger_c;
  logic [CW-1:0] n_trig_c;

  assign pop_c      = m_valid && m_ready;
  assign occ_next_c = {1'b0, held} + {2'b00, inflight_q} - {2'b00, pop_c};
  assign rd_go      = !sclr && (state_q == BURST) && (issued_q < n_q) && !fifo_empty
                      && (occ_next_c < 3'd2) && skid_in_ready_c;
  assign fifo_rd_en = rd_go;
  assign busy       = (state_q == BURST) || inflight_q || (held != 2'd0);

  assign partial_c = (fifo_usedw != '0) && (fifo_usedw < BL_U);
  assign trigger_c = enable && (fifo_usedw != '0)
                     && ((fifo_usedw >= BL_U) || flush || ((TIMEOUT != 0) && (timer_q == TO_T)));
  assign n_trig_c  = (fifo_usedw >= BL_U) ? CW'(BURST_LEN) : CW'(fifo_usedw);

  // The last tag is attached when read number N issues and follows the word
  // through the one-cycle FIFO read latency.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    n_d             = n_q;
    issued_d        = issued_q;
    inflight_d      = rd_go;
    inflight_last_d = rd_go && ((issued_q + CW'(1)) == n_q);
    unique case (state_q)
      IDLE: begin
        issued_d = '0;
        if (enable && partial_c) timer_d = (timer_q == TO_T) ? timer_q : timer_q + TW'(1);
        else                     timer_d = '0;
        if (trigger_c) begin
          n_d     = n_trig_c;
          timer_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        timer_d = '0;
        if (rd_go) begin
          issued_d = issued_q + CW'(1);
          if ((issued_q + CW'(1)) == n_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      n_q             <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      n_q             <= n_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .sclr        (sclr),
    .in_valid    (inflight_q),
    .in_data     (fifo_dout),
    .in_last     (inflight_last_q),
    .in_ready_c  (skid_in_ready_c),
    .out_valid_c (m_valid),
    .out_data_c  (m_data),
    .out_last_c  (m_last),
    .out_ready   (m_ready),
    .held        (held)
  );

endmodule
